alu_mc: RTL and testbench

ALU_MC -- requirements
Module: alu_mc

---
 rtl/alu_pkg.sv | 38 +++
 rtl/alu_muldiv.sv | 94 +++++++++
 rtl/alu_mc.sv | 156 +++++++++++++++
 tb/tb_alu_mc.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU.
// Contents:
//   - 4-bit opcode encodings for every operation the ALU understands
//   - FSM state enum used by the ALU controller
//   - mode select for the iterative multiply/divide engine
//   - fixed result returned for a divide by zero (truncated to W by the user)
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MULT = 4'b0010;
  localparam logic [3:0] OP_DIV  = 4'b0011;
  localparam logic [3:0] OP_OR   = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_SLT  = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b0111;
  localparam logic [3:0] OP_ADDI = 4'b1000;
  localparam logic [3:0] OP_SLTI = 4'b1001;
  localparam logic [3:0] OP_ANDI = 4'b1010;
  localparam logic [3:0] OP_ORI  = 4'b1011;
  localparam logic [3:0] OP_SW   = 4'b1100;
  localparam logic [3:0] OP_LW   = 4'b1101;

  // All ones at the widest legal W; users take the low W bits.
  localparam logic [63:0] DIV_ZERO_RESULT = '1;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_e;

  typedef enum logic {
    MD_MULT,
    MD_DIV
  } md_mode_e;

endpackage

// File: rtl/alu_muldiv.sv
// Iterative multiply / divide engine.
// Ports:
//   clk, rst   - clock and synchronous active-high reset
//   start_i    - load operands and begin a W-step operation
//   mode_i     - MD_MULT (shift-add, low W bits) or MD_DIV (restoring, quotient)
//   opA_i      - multiplicand / dividend
//   opB_i      - multiplier / divisor (divisor must be non-zero)
//   done_o     - high during the cycle whose closing edge performs step W
//   result_o   - value valid alongside done_o (result after the final step)
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start_i,
  input  md_mode_e     mode_i,
  input  logic [W-1:0] opA_i,
  input  logic [W-1:0] opB_i,
  output logic         done_o,
  output logic [W-1:0] result_o
);

  localparam int CNT_W = $clog2(W) + 1;

  // opA_q: multiplicand (shifts left) or dividend/quotient shift register.
  // opB_q: multiplier (shifts right) or constant divisor.
  // acc_q: product accumulator or partial remainder.
  logic             busy_q;
  md_mode_e         mode_q;
  logic [CNT_W-1:0] cnt_q;
  logic [W-1:0]     opA_q, opA_d;
  logic [W-1:0]     opB_q, opB_d;
  logic [W-1:0]     acc_q, acc_d;

  logic [W:0]       divTrial;
  logic [W+1:0]     divDiff;
  logic             divNeg;

  // One step of either algorithm. The divide step shifts the next dividend
  // bit into the remainder, trial-subtracts the divisor and restores on a
  // borrow; the quotient bit enters at the bottom of opA_q as the dividend
  // bits leave at the top.
  always_comb begin
    divTrial = {acc_q, opA_q[W-1]};
    divDiff  = {1'b0, divTrial} - {2'b00, opB_q};
    divNeg   = divDiff[W+1];
    opA_d    = opA_q;
    opB_d    = opB_q;
    acc_d    = acc_q;
    if (mode_q == MD_MULT) begin
      opA_d = opA_q << 1;
      opB_d = opB_q >> 1;
      acc_d = opB_q[0] ? (acc_q + opA_q) : acc_q;
    end else begin
      opA_d = {opA_q[W-2:0], ~divNeg};
      acc_d = divNeg ? divTrial[W-1:0] : divDiff[W-1:0];
    end
  end

  // The result is taken from the step being performed so the controller can
  // capture it on the same edge that completes step W.
  assign result_o = (mode_q == MD_MULT) ? acc_d : opA_d;
  assign done_o   = busy_q && (cnt_q == CNT_W'(W - 1));

  // Load on start, otherwise advance one step per cycle while busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      mode_q <= MD_MULT;
      cnt_q  <= '0;
      opA_q  <= '0;
      opB_q  <= '0;
      acc_q  <= '0;
    end else if (start_i) begin
      busy_q <= 1'b1;
      mode_q <= mode_i;
      cnt_q  <= '0;
      opA_q  <= opA_i;
      opB_q  <= opB_i;
      acc_q  <= '0;
    end else if (busy_q) begin
      opA_q <= opA_d;
      opB_q <= opB_d;
      acc_q <= acc_d;
      cnt_q <= cnt_q + CNT_W'(1);
      if (done_o) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes on both sides.
// Single-cycle ops complete one cycle after acceptance; MULT and DIV run on
// the iterative engine and complete W+1 cycles after acceptance.
// Ports:
//   clk, rst             - clock and synchronous active-high reset
//   in_valid / in_ready  - request handshake (ready only when idle)
//   Op1, Op2             - operands; Op2 low log2(W) bits are the SLL amount
//   Imm                  - immediate (sign- or zero-extended per opcode)
//   S_Op                 - opcode
//   out_valid/out_ready  - result handshake
//   R_Op, ZF, DZ         - registered result, zero flag, divide-by-zero flag
module alu_mc
  import alu_pkg::*;
#(
  parameter int W     = 32,
  parameter int IMM_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     Op1,
  input  logic [W-1:0]     Op2,
  input  logic [IMM_W-1:0] Imm,
  input  logic [3:0]       S_Op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     R_Op,
  output logic             ZF,
  output logic             DZ
);

  localparam int SH_W = $clog2(W);

  state_e       state_q, state_d;
  logic [W-1:0] result_q, result_d;
  logic         zf_q, zf_d;
  logic         dz_q, dz_d;

  logic [W-1:0] immSext;
  logic [W-1:0] immZext;
  logic [W-1:0] aluResult;
  logic         mdStart;
  md_mode_e     mdMode;
  logic         mdDone;
  logic [W-1:0] mdResult;

  // Single-cycle datapath, evaluated on the live inputs; it is only used on
  // the accepting edge, which is where the operands are captured anyway.
  always_comb begin
    immSext   = W'(signed'(Imm));
    immZext   = W'(Imm);
    aluResult = '0;
    case (S_Op)
      OP_ADD:  aluResult = Op1 + Op2;
      OP_SUB:  aluResult = Op1 - Op2;
      OP_OR:   aluResult = Op1 | Op2;
      OP_AND:  aluResult = Op1 & Op2;
      OP_SLT:  aluResult = W'(Op1 < Op2);
      OP_SLL:  aluResult = Op1 << Op2[SH_W-1:0];
      OP_ADDI: aluResult = Op1 + immSext;
      OP_SLTI: aluResult = W'(Op1 < immSext);
      OP_ANDI: aluResult = Op1 & immZext;
      OP_ORI:  aluResult = Op1 | immZext;
      OP_SW:   aluResult = Op1 + immSext;
      OP_LW:   aluResult = Op1 + immSext;
      default: aluResult = '0;
    endcase
  end

  alu_muldiv #(
    .W(W)
  ) u_muldiv (
    .clk      (clk),
    .rst      (rst),
    .start_i  (mdStart),
    .mode_i   (mdMode),
    .opA_i    (Op1),
    .opB_i    (Op2),
    .done_o   (mdDone),
    .result_o (mdResult)
  );

  // Controller next state and result registers. Flags are computed here from
  // the value being loaded so they stay registered alongside R_Op. A divide
  // by zero is resolved immediately without starting the engine.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zf_d     = zf_q;
    dz_d     = dz_q;
    mdStart  = 1'b0;
    mdMode   = MD_MULT;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (S_Op == OP_MULT) begin
            mdStart = 1'b1;
            mdMode  = MD_MULT;
            state_d = BUSY;
          end else if (S_Op == OP_DIV && Op2 == '0) begin
            result_d = DIV_ZERO_RESULT[W-1:0];
            zf_d     = 1'b0;
            dz_d     = 1'b1;
            state_d  = DONE;
          end else if (S_Op == OP_DIV) begin
            mdStart = 1'b1;
            mdMode  = MD_DIV;
            state_d = BUSY;
          end else begin
            result_d = aluResult;
            zf_d     = (aluResult == '0);
            dz_d     = 1'b0;
            state_d  = DONE;
          end
        end
      end
      BUSY: begin
        if (mdDone) begin
          result_d = mdResult;
          zf_d     = (mdResult == '0);
          dz_d     = 1'b0;
          state_d  = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers; reset wins over any handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      result_q <= '0;
      zf_q     <= 1'b1;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zf_q     <= zf_d;
      dz_q     <= dz_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign R_Op      = result_q;
  assign ZF        = zf_q;
  assign DZ        = dz_q;

endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc at W=32, IMM_W=16.
module tb_alu_mc;

  localparam int W     = 32;
  localparam int IMM_W = 16;
  localparam int MAX_WAIT = 100;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     Op1;
  logic [W-1:0]     Op2;
  logic [IMM_W-1:0] Imm;
  logic [3:0]       S_Op;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     R_Op;
  logic             ZF;
  logic             DZ;

  int assertCount = 0;
  int failCount   = 0;

  alu_mc #(
    .W     (W),
    .IMM_W (IMM_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Op1       (Op1),
    .Op2       (Op2),
    .Imm       (Imm),
    .S_Op      (S_Op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .R_Op      (R_Op),
    .ZF        (ZF),
    .DZ        (DZ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Wait for in_ready, present one request, and return the number of edges
  // from the accepting edge (counted as 1) until out_valid is seen.
  task automatic applyStimulus(input logic [3:0] op, input logic [W-1:0] a,
                               input logic [W-1:0] b, input logic [IMM_W-1:0] imm,
                               output int lat);
    int guard;
    guard = 0;
    while (in_ready !== 1'b1 && guard < MAX_WAIT) begin
      @(posedge clk);
      #1;
      guard++;
    end
    S_Op     = op;
    Op1      = a;
    Op2      = b;
    Imm      = imm;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < MAX_WAIT) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    logic sawValid;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    Op1       = '0;
    Op2       = '0;
    Imm       = '0;
    S_Op      = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("resetInReady", 64'(in_ready), 64'd1);
    checkOutput("resetOutValid", 64'(out_valid), 64'd0);
    checkOutput("resetROp", 64'(R_Op), 64'd0);
    checkOutput("resetZF", 64'(ZF), 64'd1);
    checkOutput("resetDZ", 64'(DZ), 64'd0);

    // ADD with single-cycle latency, then back to idle
    applyStimulus(4'b0000, 32'd7, 32'd5, 16'h0, lat);
    checkOutput("addLatency", 64'(lat), 64'd1);
    checkOutput("addROp", 64'(R_Op), 64'd12);
    checkOutput("addZF", 64'(ZF), 64'd0);
    checkOutput("addInReadyBusy", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("addInReadyAfter", 64'(in_ready), 64'd1);
    checkOutput("addOutValidAfter", 64'(out_valid), 64'd0);

    applyStimulus(4'b0001, 32'd5, 32'd5, 16'h0, lat);
    checkOutput("subROp", 64'(R_Op), 64'd0);
    checkOutput("subZF", 64'(ZF), 64'd1);

    applyStimulus(4'b0110, 32'd3, 32'd4, 16'h0, lat);
    checkOutput("sltROp", 64'(R_Op), 64'd1);

    applyStimulus(4'b1001, 32'd5, 32'd0, 16'hFFFF, lat);
    checkOutput("sltiROp", 64'(R_Op), 64'd1);

    applyStimulus(4'b0111, 32'd1, 32'h25, 16'h0, lat);
    checkOutput("sllROp", 64'(R_Op), 64'h20);

    applyStimulus(4'b1010, 32'hFFFF_FFFF, 32'd0, 16'h8000, lat);
    checkOutput("andiROp", 64'(R_Op), 64'h0000_8000);

    applyStimulus(4'b1101, 32'h100, 32'd0, 16'hFFFC, lat);
    checkOutput("lwROp", 64'(R_Op), 64'hFC);

    applyStimulus(4'b1110, 32'd9, 32'd3, 16'h1, lat);
    checkOutput("op14ROp", 64'(R_Op), 64'd0);
    checkOutput("op14ZF", 64'(ZF), 64'd1);
    checkOutput("op14DZ", 64'(DZ), 64'd0);

    // Iterative ops
    applyStimulus(4'b0010, 32'h0001_0000, 32'h0001_0001, 16'h0, lat);
    checkOutput("multLatency", 64'(lat), 64'd33);
    checkOutput("multROp", 64'(R_Op), 64'h0001_0000);

    applyStimulus(4'b0011, 32'd100, 32'd7, 16'h0, lat);
    checkOutput("divLatency", 64'(lat), 64'd33);
    checkOutput("divROp", 64'(R_Op), 64'd14);
    checkOutput("divDZ", 64'(DZ), 64'd0);

    // Divide by zero with a stalled consumer and a competing request
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    applyStimulus(4'b0011, 32'd9, 32'd0, 16'h0, lat);
    checkOutput("dzLatency", 64'(lat), 64'd1);
    checkOutput("dzROp", 64'(R_Op), 64'hFFFF_FFFF);
    checkOutput("dzDZ", 64'(DZ), 64'd1);
    checkOutput("dzZF", 64'(ZF), 64'd0);
    S_Op     = 4'b0000;
    Op1      = 32'd1;
    Op2      = 32'd1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checkOutput("holdOutValid", 64'(out_valid), 64'd1);
      checkOutput("holdInReady", 64'(in_ready), 64'd0);
      checkOutput("holdROp", 64'(R_Op), 64'hFFFF_FFFF);
      checkOutput("holdDZ", 64'(DZ), 64'd1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("dzReleaseInReady", 64'(in_ready), 64'd1);
    checkOutput("dzReleaseOutValid", 64'(out_valid), 64'd0);

    // Reset in the tenth cycle of a MULT aborts it
    S_Op     = 4'b0010;
    Op1      = 32'd3;
    Op2      = 32'd5;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("abortInReady", 64'(in_ready), 64'd1);
    checkOutput("abortOutValid", 64'(out_valid), 64'd0);
    checkOutput("abortROp", 64'(R_Op), 64'd0);
    checkOutput("abortZF", 64'(ZF), 64'd1);
    sawValid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) sawValid = 1'b1;
    end
    checkOutput("abortNoValid", 64'(sawValid), 64'd0);

    applyStimulus(4'b1000, 32'd0, 32'd0, 16'h8000, lat);
    checkOutput("addiLatency", 64'(lat), 64'd1);
    checkOutput("addiROp", 64'(R_Op), 64'hFFFF_8000);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
